// File: rtl/hbus_pkg.sv
// Shared types and CA packing helpers for the HyperBus Avalon front end.
package hbus_pkg;

  typedef enum logic [2:0] {
    FE_IDLE,
    FE_ISSUE,
    FE_WAIT_DONE,
    FE_WAIT_DATA,
    FE_RESP
  } fe_state_t;

  localparam int CA_RW    = 47;
  localparam int CA_AS    = 46;
  localparam int CA_BURST = 45;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Memory-space linear-burst CA word from a 32-bit byte address.
  function automatic logic [47:0] build_ca(input logic [31:0] addr, input logic is_read);
    logic [31:0] ha;
    logic [47:0] ca;
    ha           = addr >> 1;
    ca           = '0;
    ca[CA_RW]    = is_read;
    ca[CA_AS]    = 1'b0;
    ca[CA_BURST] = 1'b1;
    ca[44:16]    = ha[31:3];
    ca[2:0]      = ha[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hbus_ca_builder.sv
// Combinational CA word packing; ADDR_SPACE selects memory (0) or register (1) space.
module hbus_ca_builder
  import hbus_pkg::*;
#(
  parameter logic ADDR_SPACE = 1'b0
) (
  input  logic [31:0] addr_i,
  input  logic        is_read_i,
  output logic [47:0] ca_o
);

  always_comb begin
    ca_o        = build_ca(addr_i, is_read_i);
    ca_o[CA_AS] = ADDR_SPACE;
  end

endmodule

// File: rtl/hbus_avl_frontend.sv
// Avalon-MM single-beat front end feeding the HyperRAM transaction sequencer.
// Optional cmd_done/rsp_valid watchdog enabled by defining HBUS_FE_TIMEOUT_EN.
//   state     | meaning
//   IDLE      | waitrequest low, accepting a read or write
//   ISSUE     | one-cycle cmd_rd/cmd_wr pulse to the sequencer
//   WAIT_DONE | waiting for cmd_done (read data may arrive first)
//   WAIT_DATA | cmd_done seen on a read, waiting for rsp_valid
//   RESP      | retire; readdatavalid for reads
module hbus_avl_frontend
  import hbus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [47:0]       cmd_ca,
  output logic [31:0]       cmd_wdata,
  output logic              cmd_rd,
  output logic              cmd_wr,
  input  logic              cmd_done,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data,
  output logic              err_timeout
);

  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [31:0] addr32;
  if (ADDR_W >= 32) begin : g_addr_trunc
    assign addr32 = avs_address[31:0];
  end else begin : g_addr_ext
    assign addr32 = {{(32-ADDR_W){1'b0}}, avs_address};
  end

  logic [47:0] ca_next;

  hbus_ca_builder #(.ADDR_SPACE(1'b0)) u_ca_builder (
    .addr_i    (addr32),
    .is_read_i (avs_read),
    .ca_o      (ca_next)
  );

  fe_state_t   state_q,   state_d;
  logic        waitreq_q, waitreq_d;
  logic [47:0] ca_q,      ca_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] rdata_q,   rdata_d;
  logic        is_read_q, is_read_d;
  logic        got_rsp_q, got_rsp_d;
`ifdef HBUS_FE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed_out;
`endif

  always_comb begin
    state_d   = state_q;
    ca_d      = ca_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    got_rsp_d = got_rsp_q;
`ifdef HBUS_FE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
    timed_out = 1'b0;
    // Saturating down-counter; a zero load leaves the watchdog inert.
    if ((state_q == FE_WAIT_DONE || state_q == FE_WAIT_DATA) && cnt_q != '0) begin
      cnt_d     = cnt_q - CNT_W'(1);
      timed_out = (cnt_q == CNT_W'(1));
    end
`endif
    unique case (state_q)
      FE_IDLE: begin
        if (!waitreq_q && (avs_read || avs_write)) begin
          ca_d      = ca_next;
          wdata_d   = avs_writedata;
          is_read_d = avs_read;
          got_rsp_d = 1'b0;
          state_d   = FE_ISSUE;
        end
      end
      FE_ISSUE: begin
        state_d = FE_WAIT_DONE;
`ifdef HBUS_FE_TIMEOUT_EN
        cnt_d   = CNT_W'(TIMEOUT_CYCLES);
`endif
      end
      FE_WAIT_DONE: begin
        if (rsp_valid && is_read_q) begin
          rdata_d   = rsp_data;
          got_rsp_d = 1'b1;
        end
        if (cmd_done) begin
          state_d = (!is_read_q || got_rsp_q || rsp_valid) ? FE_RESP : FE_WAIT_DATA;
        end
`ifdef HBUS_FE_TIMEOUT_EN
        else if (timed_out) begin
          state_d = FE_RESP;
          err_d   = 1'b1;
          rdata_d = TIMEOUT_DATA;
        end
`endif
      end
      FE_WAIT_DATA: begin
        if (rsp_valid) begin
          rdata_d = rsp_data;
          state_d = FE_RESP;
        end
`ifdef HBUS_FE_TIMEOUT_EN
        else if (timed_out) begin
          state_d = FE_RESP;
          err_d   = 1'b1;
          rdata_d = TIMEOUT_DATA;
        end
`endif
      end
      FE_RESP: state_d = FE_IDLE;
      default: state_d = FE_IDLE;
    endcase
    waitreq_d = (state_d != FE_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FE_IDLE;
      waitreq_q <= 1'b1;
      ca_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_read_q <= 1'b0;
      got_rsp_q <= 1'b0;
`ifdef HBUS_FE_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      waitreq_q <= waitreq_d;
      ca_q      <= ca_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      got_rsp_q <= got_rsp_d;
`ifdef HBUS_FE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign avs_waitrequest   = waitreq_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = (state_q == FE_RESP) && is_read_q;
  assign cmd_ca            = ca_q;
  assign cmd_wdata         = wdata_q;
  assign cmd_rd            = (state_q == FE_ISSUE) && is_read_q;
  assign cmd_wr            = (state_q == FE_ISSUE) && !is_read_q;
`ifdef HBUS_FE_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hbus_avl_frontend.sv
// Directed plus randomized bench for hbus_avl_frontend with a cycle-window reference model.
module tb_hbus_avl_frontend;

  localparam int TO    = 16;
  localparam int NEVER = 100000;
`ifdef HBUS_FE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic [47:0] cmd_ca;
  logic [31:0] cmd_wdata;
  logic        cmd_rd, cmd_wr, cmd_done, rsp_valid;
  logic [31:0] rsp_data;
  logic        err_timeout;

  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  hbus_avl_frontend #(.ADDR_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(11)) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .cmd_ca            (cmd_ca),
    .cmd_wdata         (cmd_wdata),
    .cmd_rd            (cmd_rd),
    .cmd_wr            (cmd_wr),
    .cmd_done          (cmd_done),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .err_timeout       (err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CA from plain arithmetic on the halfword address.
  function automatic logic [47:0] exp_ca(input bit rd, input logic [31:0] a);
    logic [47:0] ha;
    ha = {16'h0, a} / 48'd2;
    return (rd ? 48'h8000_0000_0000 : 48'h0) + 48'h2000_0000_0000
           + ((ha / 48'd8) * 48'd65536) + (ha % 48'd8);
  endfunction

  task automatic chk_reset_vals();
    chk("rst_waitreq", 64'(avs_waitrequest),   64'(1));
    chk("rst_rdv",     64'(avs_readdatavalid), 64'(0));
    chk("rst_rdata",   64'(avs_readdata),      64'(0));
    chk("rst_cmd_rd",  64'(cmd_rd),            64'(0));
    chk("rst_cmd_wr",  64'(cmd_wr),            64'(0));
    chk("rst_ca",      64'(cmd_ca),            64'(0));
    chk("rst_wdata",   64'(cmd_wdata),         64'(0));
    chk("rst_err",     64'(err_timeout),       64'(0));
  endtask

  // Window w=0 is the accept cycle; sequencer events land D (cmd_done) and R (rsp_valid)
  // windows after the cmd pulse window w=1.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input int d, input int r);
    int          ev, resp_w;
    bit          timed;
    logic [47:0] ca;
    ca     = exp_ca(rd, addr);
    ev     = rd ? (((d > r) ? d : r) + 1) : (d + 1);
    timed  = TO_EN && (TO != 0) && (ev > TO + 1);
    resp_w = timed ? TO + 2 : ev + 1;
    chk("accept_waitreq", 64'(avs_waitrequest), 64'(0));
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = addr;
    avs_writedata = wdat;
    cmd_done      = 1'b0;
    rsp_valid     = 1'b0;
    for (int w = 1; w <= resp_w + 1; w++) begin
      step();
      if (w == 1) begin
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = $urandom;
        avs_writedata = $urandom;
      end
      cmd_done  = (w == d + 1);
      rsp_valid = rd && (w == r + 1);
      rsp_data  = rsp_valid ? rdat : $urandom;
      if (timed && w == resp_w) exp_err = 1'b1;
      chk("waitreq", 64'(avs_waitrequest), 64'(w <= resp_w));
      chk("cmd_rd",  64'(cmd_rd), 64'(w == 1 && rd));
      chk("cmd_wr",  64'(cmd_wr), 64'(w == 1 && !rd));
      if (w <= resp_w) begin
        chk("cmd_ca",    64'(cmd_ca),    64'(ca));
        chk("cmd_wdata", 64'(cmd_wdata), 64'(wdat));
      end
      chk("rdv", 64'(avs_readdatavalid), 64'(rd && w == resp_w));
      if (rd && w == resp_w)
        chk("rdata", 64'(avs_readdata), 64'(timed ? 32'hDEAD_BEEF : rdat));
      chk("err_timeout", 64'(err_timeout), 64'(exp_err));
    end
    cmd_done  = 1'b0;
    rsp_valid = 1'b0;
  endtask

  // Stray sequencer strobes while idle must not start or retire anything.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_done  = 1'($urandom_range(0, 1));
      rsp_valid = 1'($urandom_range(0, 1));
      rsp_data  = $urandom;
      step();
      chk("idle_waitreq", 64'(avs_waitrequest),   64'(0));
      chk("idle_cmd",     64'(cmd_rd | cmd_wr),   64'(0));
      chk("idle_rdv",     64'(avs_readdatavalid), 64'(0));
    end
    cmd_done  = 1'b0;
    rsp_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    exp_err = 1'b0;
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk("post_rst_waitreq", 64'(avs_waitrequest), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    cmd_done = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    step(); step(); step();
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk("first_idle_waitreq", 64'(avs_waitrequest), 64'(0));

    run_txn(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 3, NEVER);
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 4, 1);
    run_txn(1'b1, 1'b0, 32'h0000_0A48, 32'h5555_AAAA, 32'h0BAD_CAFE, 1, 6);
    run_txn(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 32'h1357_9BDF, 2, 2);
    idle(3);

    // Reset while waiting on the sequencer; the late completion must be dropped.
    avs_read = 1'b1; avs_address = 32'h0000_2000;
    step();
    avs_read = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    exp_err = 1'b0;
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk("rst_mid_waitreq", 64'(avs_waitrequest), 64'(0));
    cmd_done = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_done = 1'b0; rsp_valid = 1'b0;
      chk("late_done_rdv",     64'(avs_readdatavalid), 64'(0));
      chk("late_done_waitreq", 64'(avs_waitrequest),   64'(0));
      chk("late_done_cmd",     64'(cmd_rd | cmd_wr),   64'(0));
    end

`ifdef HBUS_FE_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0, NEVER, NEVER);
    run_txn(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'hA5A5_5A5A, 2, 3);
    run_txn(1'b0, 1'b1, 32'h0000_0408, 32'h0F0F_F0F0, 32'h0, NEVER, NEVER);
    run_txn(1'b1, 1'b0, 32'h0000_040C, 32'h0, 32'h2468_ACE0, TO, 1);
    apply_reset();
`endif

    for (int n = 0; n < 150; n++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
              $urandom_range(1, 8), $urandom_range(1, 8));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
